// File: rtl/latch_bank_ctrl_pkg.sv
// Shared definitions for the latch bank write controller: FSM encoding,
// default geometry and a small constant helper.
package latch_ctrl_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/latch_bank_ctrl_if.sv
// Requester-side bus of the latch bank controller: flattened per-requester
// request/address/data in, one-hot grant/ack and error pulse out.
interface latch_bank_ctrl_if
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);

  logic [NREQ-1:0]       req_in;
  logic [NREQ*AW-1:0]    addr_in;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt_out;
  logic [NREQ-1:0]       ack_out;
  logic                  err_out;

  modport master (
    output req_in, addr_in, data_in,
    input  gnt_out, ack_out, err_out
  );

  modport slave (
    input  req_in, addr_in, data_in,
    output gnt_out, ack_out, err_out
  );

endinterface

// File: rtl/latch_bank_ctrl_arb.sv
// Round-robin arbiter: the requester just after ptr has highest priority,
// so the previous winner (held in ptr) is served last.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            upd,
  output logic [NREQ-1:0] gnt
);

  logic found;

  // Grant is only asserted while upd is high, so callers can use it directly as a load enable.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    gnt   = '0;
    found = 1'b0;
    if (upd) begin
      for (int off = 1; off <= NREQ; off++) begin
        if (!found && req[(int'(ptr) + off) % NREQ]) begin
          gnt[(int'(ptr) + off) % NREQ] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write sequencer for a bank of level-sensitive latches: arbitrates the
// requesters, then drives captured data through setup, a single enable
// pulse and hold, so data never moves while a latch is transparent.
module latch_bank_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AW        = DEF_AW,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  latch_bank_ctrl_if.slave   bus,
  output logic [WIDTH-1:0]   latch_d_out,
  output logic [DEPTH-1:0]   latch_en_out,
  output logic               busy_out
);

  localparam int CW = $clog2(max2(SETUP_CYC, HOLD_CYC)) + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic              bad_q, bad_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [DEPTH-1:0]  en_q, en_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   win;
  logic [PW-1:0]     win_idx;
  logic [AW-1:0]     win_addr;
  logic [WIDTH-1:0]  win_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (bus.req_in),
    .ptr (ptr_q),
    .upd (state_q == ST_IDLE),
    .gnt (win)
  );

  // Select the winning requester's index, address and data slice.
  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        win_idx  = PW'(i);
        win_addr = bus.addr_in[i*AW +: AW];
        win_data = bus.data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and registered-output logic of the write sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    err_d   = 1'b0;
    bad_d   = bad_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|win) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          ptr_d   = win_idx;
          gnt_d   = win;
          addr_d  = win_addr;
          data_d  = win_data;
          bad_d   = (int'(win_addr) >= DEPTH);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ENABLE;
          if (!bad_q) en_d[addr_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ENABLE: begin
        state_d = ST_HOLD;
        cnt_d   = CW'(HOLD_CYC - 1);
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          ack_d   = gnt_q;
          gnt_d   = '0;
          err_d   = bad_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state is updated with non-blocking assignments so all flops sample together.
    if (rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt_out   = gnt_q;
  assign bus.ack_out   = ack_q;
  assign bus.err_out   = err_q;
  assign latch_d_out   = data_q;
  assign latch_en_out  = en_q;
  assign busy_out      = busy_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Directed bench for latch_bank_ctrl: default instance, a DEPTH=3 instance
// for the bad-address case, and a SETUP_CYC=3/HOLD_CYC=2 instance.
module tb_latch_bank_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   waited;

  always #5 clk = ~clk;

  latch_bank_ctrl_if #(.NREQ(4), .WIDTH(8), .AW(2)) if_def ();
  latch_bank_ctrl_if #(.NREQ(4), .WIDTH(8), .AW(2)) if_bad ();
  latch_bank_ctrl_if #(.NREQ(4), .WIDTH(8), .AW(2)) if_swp ();

  logic [7:0] d_def, d_bad, d_swp;
  logic [3:0] en_def, en_swp;
  logic [2:0] en_bad;
  logic       busy_def, busy_bad, busy_swp;

  latch_bank_ctrl #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2), .SETUP_CYC(1), .HOLD_CYC(1)) u_def (
    .clk_in(clk), .rst_in(rst), .bus(if_def.slave),
    .latch_d_out(d_def), .latch_en_out(en_def), .busy_out(busy_def)
  );

  latch_bank_ctrl #(.NREQ(4), .WIDTH(8), .DEPTH(3), .AW(2), .SETUP_CYC(1), .HOLD_CYC(1)) u_bad (
    .clk_in(clk), .rst_in(rst), .bus(if_bad.slave),
    .latch_d_out(d_bad), .latch_en_out(en_bad), .busy_out(busy_bad)
  );

  latch_bank_ctrl #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2), .SETUP_CYC(3), .HOLD_CYC(2)) u_swp (
    .clk_in(clk), .rst_in(rst), .bus(if_swp.slave),
    .latch_d_out(d_swp), .latch_en_out(en_swp), .busy_out(busy_swp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    if_def.req_in = '0; if_def.addr_in = '0; if_def.data_in = '0;
    if_bad.req_in = '0; if_bad.addr_in = '0; if_bad.data_in = '0;
    if_swp.req_in = '0; if_swp.addr_in = '0; if_swp.data_in = '0;
    repeat (2) tick();

    // Reset state
    check("rst_gnt",  32'(if_def.gnt_out), 32'h0);
    check("rst_ack",  32'(if_def.ack_out), 32'h0);
    check("rst_err",  32'(if_def.err_out), 32'h0);
    check("rst_d",    32'(d_def),          32'h0);
    check("rst_en",   32'(en_def),         32'h0);
    check("rst_busy", 32'(busy_def),       32'h0);
    rst = 1'b0;

    // Single write: requester 0, addr 2, data A5; data changed to 3C at T+2
    if_def.req_in        = 4'b0001;
    if_def.addr_in[1:0]  = 2'd2;
    if_def.data_in[7:0]  = 8'hA5;
    tick();  // T+1
    check("sw_busy_t1", 32'(busy_def),       32'h1);
    check("sw_gnt_t1",  32'(if_def.gnt_out), 32'h1);
    check("sw_d_t1",    32'(d_def),          32'hA5);
    check("sw_en_t1",   32'(en_def),         32'h0);
    tick();  // T+2
    check("sw_en_t2",   32'(en_def),         32'h4);
    check("sw_d_t2",    32'(d_def),          32'hA5);
    if_def.data_in[7:0] = 8'h3C;
    tick();  // T+3
    check("sw_en_t3",   32'(en_def),         32'h0);
    check("sw_d_t3",    32'(d_def),          32'hA5);
    tick();  // T+4
    check("sw_ack_t4",  32'(if_def.ack_out), 32'h1);
    check("sw_gnt_t4",  32'(if_def.gnt_out), 32'h0);
    check("sw_err_t4",  32'(if_def.err_out), 32'h0);
    check("sw_d_t4",    32'(d_def),          32'hA5);
    if_def.req_in = '0;
    tick();  // T+5
    check("sw_ack_t5",  32'(if_def.ack_out), 32'h0);
    check("sw_busy_t5", 32'(busy_def),       32'h0);
    check("sw_d_t5",    32'(d_def),          32'hA5);

    // Contention: all four request, each drops on its ack; two rounds from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_def.addr_in = {2'd3, 2'd2, 2'd1, 2'd0};
    if_def.data_in = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int r = 0; r < 2; r++) begin
      if_def.req_in = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        waited = 0;
        while (if_def.ack_out == '0 && waited < 12) begin
          tick();
          waited++;
        end
        check($sformatf("rr_ack_r%0d_k%0d", r, k), 32'(if_def.ack_out), 32'(4'b0001 << k));
        check($sformatf("rr_d_r%0d_k%0d", r, k),   32'(d_def),          32'(8'h10 + k));
        if_def.req_in[k] = 1'b0;
        tick();
      end
    end

    // Reset in ENABLE: requester 2 writing addr 1
    if_def.req_in          = 4'b0100;
    if_def.addr_in[5:4]    = 2'd1;
    if_def.data_in[23:16]  = 8'h77;
    tick();
    check("mr_gnt_setup", 32'(if_def.gnt_out), 32'h4);
    tick();
    check("mr_en_enable", 32'(en_def),         32'h2);
    rst = 1'b1;
    tick();
    check("mr_en_rst",    32'(en_def),         32'h0);
    check("mr_gnt_rst",   32'(if_def.gnt_out), 32'h0);
    check("mr_ack_rst",   32'(if_def.ack_out), 32'h0);
    check("mr_busy_rst",  32'(busy_def),       32'h0);
    check("mr_d_rst",     32'(d_def),          32'h0);
    rst = 1'b0;
    if_def.req_in        = 4'b0101;
    if_def.addr_in[1:0]  = 2'd3;
    if_def.data_in[7:0]  = 8'h11;
    tick();
    check("mr_gnt_after", 32'(if_def.gnt_out), 32'h1);
    repeat (3) tick();
    check("mr_ack_after", 32'(if_def.ack_out), 32'h1);
    check("mr_d_after",   32'(d_def),          32'h11);
    if_def.req_in = '0;
    tick();

    // Bad address on DEPTH=3 instance
    if_bad.req_in       = 4'b0001;
    if_bad.addr_in[1:0] = 2'd3;
    if_bad.data_in[7:0] = 8'h5A;
    repeat (2) tick();  // T+2
    check("bad_en_t2",  32'(en_bad),         32'h0);
    check("bad_err_t2", 32'(if_bad.err_out), 32'h0);
    tick();             // T+3
    check("bad_en_t3",  32'(en_bad),         32'h0);
    tick();             // T+4
    check("bad_ack_t4", 32'(if_bad.ack_out), 32'h1);
    check("bad_err_t4", 32'(if_bad.err_out), 32'h1);
    if_bad.req_in = '0;
    tick();             // T+5
    check("bad_err_t5",  32'(if_bad.err_out), 32'h0);
    check("bad_busy_t5", 32'(busy_bad),       32'h0);

    // SETUP_CYC=3, HOLD_CYC=2: enable at T+4, ack at T+7
    if_swp.req_in       = 4'b0001;
    if_swp.addr_in[1:0] = 2'd1;
    if_swp.data_in[7:0] = 8'hC3;
    tick();             // T+1
    check("swp_d_t1",  32'(d_swp),  32'hC3);
    check("swp_en_t1", 32'(en_swp), 32'h0);
    if_swp.data_in[7:0] = 8'hFF;
    repeat (2) tick();  // T+3
    check("swp_en_t3", 32'(en_swp), 32'h0);
    tick();             // T+4
    check("swp_en_t4", 32'(en_swp), 32'h2);
    check("swp_d_t4",  32'(d_swp),  32'hC3);
    tick();             // T+5
    check("swp_en_t5", 32'(en_swp), 32'h0);
    tick();             // T+6
    check("swp_ack_t6", 32'(if_swp.ack_out), 32'h0);
    tick();             // T+7
    check("swp_ack_t7", 32'(if_swp.ack_out), 32'h1);
    check("swp_d_t7",   32'(d_swp),          32'hC3);
    if_swp.req_in = '0;
    tick();             // T+8
    check("swp_ack_t8",  32'(if_swp.ack_out), 32'h0);
    check("swp_busy_t8", 32'(busy_swp),       32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
